bike_light_multi_fsm: RTL and testbench

- Parametrised successor to the single-channel bicycle light controller. Drives NUM_CH independent lights, for example front and rear.
- Each channel has its own mode register and its own adjustable flash periods, plus a new PWM dim mode.
- Contains one shared beat generator. The existing master FSM, beat and blinker structure is folded into per-channel sequential logic.
- Buttons are pre-debounced single-cycle pulses and act only on the channel addressed by sel.

---
 rtl/bike_light_multi_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_bike_light_multi_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bike_light_multi_fsm.sv
// ----------------------------------------------------------------------------
// bike_light_multi_fsm
//   Multi-channel bicycle light controller. One shared beat generator and one
//   shared 4-bit PWM counter feed NUM_CH independent channels. Each channel
//   holds its own mode, FLASH_1/FLASH_2 half-periods (in beats), DIM duty, and
//   flash phase. Buttons act only on the channel addressed by sel.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   sel       in   channel addressed by the buttons
//   next      in   1-cycle pulse, advance selected channel's mode
//   faster    in   1-cycle pulse, shorter flash period / higher DIM duty
//   slower    in   1-cycle pulse, longer flash period / lower DIM duty
//   light     out  registered light drive, one bit per channel
//   sel_mode  out  registered mode of channel sel (0 if sel out of range)
//   beat      out  registered 1-cycle beat pulse
// ----------------------------------------------------------------------------
module bike_light_multi_fsm #(
   parameter int  NUM_CH    = 2,
   parameter int  BEAT_DIV  = 1562500,
   parameter int  PER_W     = 5,
   parameter int  F1_INIT   = 16,
   parameter int  F2_INIT   = 4,
   parameter int  DUTY_INIT = 4,
   localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SEL_W-1:0]  sel,
   input  logic              next,
   input  logic              faster,
   input  logic              slower,
   output logic [NUM_CH-1:0] light,
   output logic [2:0]        sel_mode,
   output logic              beat
);

   localparam int CNT_W = $clog2(BEAT_DIV);
   localparam logic [PER_W-1:0] HALF_MAX = '1;

   typedef enum logic [2:0] {
      M_OFF = 3'd0,
      M_ON  = 3'd1,
      M_FL1 = 3'd2,
      M_FL2 = 3'd3,
      M_DIM = 3'd4
   } mode_e;

   // ---------------- shared beat generator and PWM counter ----------------
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic             beat_q;
   logic             tick;
   logic [3:0]       pwm_q;

   // tick is the cycle the counter sits at its top value; the channels advance
   // their flash phase on the same edge that raises beat.
   assign tick   = (bcnt_q == CNT_W'(BEAT_DIV - 1));
   assign bcnt_d = tick ? '0 : bcnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcnt_q <= '0;
         beat_q <= 1'b0;
         pwm_q  <= 4'd0;
      end else begin
         bcnt_q <= bcnt_d;
         beat_q <= tick;
         pwm_q  <= pwm_q + 4'd1;
      end
   end

   // ---------------- channel addressing and sel_mode mux ------------------
   logic [NUM_CH-1:0]      sel_hit;
   logic [NUM_CH-1:0][2:0] mode_all;
   logic [NUM_CH-1:0]      light_all;
   logic [2:0]             sel_mode_q, sel_mode_d;

   // An out-of-range sel matches no channel, so buttons are dropped and
   // sel_mode falls back to 0.
   always_comb begin
      sel_hit    = '0;
      sel_mode_d = 3'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel_hit[i] = (32'(sel) == i);
         if (sel_hit[i]) sel_mode_d = mode_all[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sel_mode_q <= 3'd0;
      else        sel_mode_q <= sel_mode_d;
   end

   // ---------------- per-channel state ------------------------------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      mode_e            mode_q, mode_d;
      logic [PER_W-1:0] h1_q, h1_d, h2_q, h2_d, ph_q, ph_d, half;
      logic [PER_W:0]   ph_inc;
      logic [3:0]       duty_q, duty_d;
      logic             fs_q, fs_d, lt_q, lt_d, flashing, btn;

      assign btn          = sel_hit[g];
      assign mode_all[g]  = mode_q;
      assign light_all[g] = lt_q;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            mode_q <= M_OFF;
            h1_q   <= PER_W'(F1_INIT);
            h2_q   <= PER_W'(F2_INIT);
            duty_q <= 4'(DUTY_INIT);
            ph_q   <= '0;
            fs_q   <= 1'b0;
            lt_q   <= 1'b0;
         end else begin
            mode_q <= mode_d;
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            duty_q <= duty_d;
            ph_q   <= ph_d;
            fs_q   <= fs_d;
            lt_q   <= lt_d;
         end
      end

      always_comb begin
         mode_d   = mode_q;
         h1_d     = h1_q;
         h2_d     = h2_q;
         duty_d   = duty_q;
         ph_d     = ph_q;
         fs_d     = fs_q;
         lt_d     = 1'b0;
         flashing = (mode_q == M_FL1) || (mode_q == M_FL2);
         half     = (mode_q == M_FL2) ? h2_q : h1_q;
         ph_inc   = {1'b0, ph_q} + (PER_W + 1)'(1);

         // >= rather than == so a half-period shortened below the current
         // phase still toggles on the very next beat.
         if (tick && flashing) begin
            if (ph_inc >= {1'b0, half}) begin
               ph_d = '0;
               fs_d = ~fs_q;
            end else begin
               ph_d = ph_inc[PER_W-1:0];
            end
         end

         if (btn && next) begin
            case (mode_q)
               M_OFF:   mode_d = M_ON;
               M_ON:    mode_d = M_FL1;
               M_FL1:   mode_d = M_FL2;
               M_FL2:   mode_d = M_DIM;
               default: mode_d = M_OFF;   // DIM and illegal codes
            endcase
            // Flash entry starts lit with a fresh phase; harmless elsewhere.
            ph_d = '0;
            fs_d = 1'b1;
         end else if (btn && (faster ^ slower)) begin
            case (mode_q)
               M_FL1: begin
                  if (faster) begin
                     if (h1_q > PER_W'(1)) h1_d = h1_q - PER_W'(1);
                  end else if (h1_q != HALF_MAX) begin
                     h1_d = h1_q + PER_W'(1);
                  end
               end
               M_FL2: begin
                  if (faster) begin
                     if (h2_q > PER_W'(1)) h2_d = h2_q - PER_W'(1);
                  end else if (h2_q != HALF_MAX) begin
                     h2_d = h2_q + PER_W'(1);
                  end
               end
               M_DIM: begin
                  if (faster) begin
                     if (duty_q != 4'hF) duty_d = duty_q + 4'd1;
                  end else if (duty_q != 4'h0) begin
                     duty_d = duty_q - 4'd1;
                  end
               end
               default: ;
            endcase
         end

         case (mode_q)
            M_ON:         lt_d = 1'b1;
            M_FL1, M_FL2: lt_d = fs_q;
            M_DIM:        lt_d = (pwm_q < duty_q);
            default:      lt_d = 1'b0;
         endcase
      end
   end

   assign light    = light_all;
   assign sel_mode = sel_mode_q;
   assign beat     = beat_q;

endmodule

// File: tb/tb_bike_light_multi_fsm.sv
// ----------------------------------------------------------------------------
// tb_bike_light_multi_fsm
//   Scoreboard bench: expected values are queued when stimulus is applied and
//   popped when the matching output is sampled. A second instance with
//   NUM_CH=3 is held at sel=3 so every button press it sees must be ignored.
// ----------------------------------------------------------------------------
module tb_bike_light_multi_fsm;

   logic       clk = 1'b0, reset = 1'b0;
   logic       sel = 1'b0, next = 1'b0, faster = 1'b0, slower = 1'b0;
   logic [1:0] sel3 = 2'd3;
   logic [1:0] light;
   logic [2:0] sel_mode;
   logic       beat;
   logic [2:0] light3;
   logic [2:0] sel_mode3;
   logic       beat3;

   int    n_chk = 0, n_pass = 0;
   string tag_q[$];
   int    exp_q[$];
   int    c;

   always #5 clk = ~clk;

   bike_light_multi_fsm #(
      .NUM_CH(2), .BEAT_DIV(4), .PER_W(5), .F1_INIT(3), .F2_INIT(1), .DUTY_INIT(4)
   ) u_dut (
      .clk(clk), .reset(reset), .sel(sel), .next(next), .faster(faster),
      .slower(slower), .light(light), .sel_mode(sel_mode), .beat(beat)
   );

   bike_light_multi_fsm #(
      .NUM_CH(3), .BEAT_DIV(4), .PER_W(5), .F1_INIT(3), .F2_INIT(1), .DUTY_INIT(4)
   ) u_dut3 (
      .clk(clk), .reset(reset), .sel(sel3), .next(next), .faster(faster),
      .slower(slower), .light(light3), .sel_mode(sel_mode3), .beat(beat3)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
   endtask

   function automatic void expect_v(input string tag, input int v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endfunction

   task automatic observe(input int got);
      if (exp_q.size() == 0) chk("sb_underflow", got, -1);
      else chk(tag_q.pop_front(), got, exp_q.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic n, input logic f, input logic s, input int reps);
      next = n; faster = f; slower = s;
      repeat (reps) tick();
      next = 1'b0; faster = 1'b0; slower = 1'b0;
   endtask

   // Cycles between two consecutive toggles of light[ch]; -1 on timeout.
   task automatic meas_half(input int ch, output int cyc);
      logic prev;
      int   n;
      cyc  = -1;
      prev = light[ch];
      n    = 0;
      while (light[ch] == prev && n < 300) begin tick(); n++; end
      if (light[ch] == prev) return;
      prev = light[ch];
      n    = 0;
      while (light[ch] == prev && n < 300) begin tick(); n++; end
      if (light[ch] != prev) cyc = n;
   endtask

   // High cycles of light[ch] over one full 16-cycle PWM period.
   task automatic dim_count(input int ch, output int n);
      n = 0;
      repeat (16) begin tick(); n += int'(light[ch]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      expect_v("rst_light", 0);    observe(int'(light));
      expect_v("rst_selmode", 0);  observe(int'(sel_mode));
      expect_v("rst_beat", 0);     observe(int'(beat));

      // beat: first pulse on the 4th edge after release, then every 4th
      @(negedge clk) reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         expect_v("beat", int'(k % 4 == 0));
         tick();
         observe(int'(beat));
      end

      // channel 1: OFF -> ON -> FLASH_1
      sel = 1'b1;
      press(1, 0, 0, 1);
      expect_v("ch1_on", 1); tick(); observe(int'(sel_mode));
      press(1, 0, 0, 1);
      expect_v("ch1_fl1", 2);
      expect_v("ch1_lit", 1);
      expect_v("ch0_dark", 0);
      tick();
      observe(int'(sel_mode)); observe(int'(light[1])); observe(int'(light[0]));
      expect_v("f1_init", 12);  meas_half(1, c); observe(c);

      press(0, 1, 0, 5);
      expect_v("f1_min", 4);    meas_half(1, c); observe(c);
      press(0, 0, 1, 40);
      expect_v("f1_max", 124);  meas_half(1, c); observe(c);

      // next wins over faster; faster+slower is ignored
      press(1, 1, 0, 1);
      expect_v("next_wins", 3); tick(); observe(int'(sel_mode));
      expect_v("f2_init", 4);   meas_half(1, c); observe(c);
      press(0, 1, 1, 3);
      expect_v("f2_both", 4);   meas_half(1, c); observe(c);
      press(1, 0, 0, 4);
      expect_v("back_fl1", 2);  tick(); observe(int'(sel_mode));
      expect_v("f1_kept", 124); meas_half(1, c); observe(c);

      // channel 0 into DIM
      sel = 1'b0;
      press(1, 0, 0, 4);
      expect_v("ch0_dim", 4);   tick(); observe(int'(sel_mode));
      tick();
      expect_v("duty4", 4);     dim_count(0, c); observe(c);
      press(0, 0, 1, 5);
      tick();
      expect_v("duty0", 0);     dim_count(0, c); observe(c);
      press(0, 1, 0, 20);
      tick();
      expect_v("duty15", 15);   dim_count(0, c); observe(c);
      sel = 1'b1;
      expect_v("ch1_untouched", 2); tick(); observe(int'(sel_mode));

      // out-of-range sel on the 3-channel instance: nothing ever changed
      expect_v("oor_selmode", 0); observe(int'(sel_mode3));
      expect_v("oor_light", 0);   observe(int'(light3));
      for (int s = 0; s < 3; s++) begin
         sel3 = 2'(s);
         expect_v("oor_chmode", 0);
         tick();
         observe(int'(sel_mode3));
      end
      sel3 = 2'd3;

      // reset while both channels flash
      sel = 1'b0;
      press(1, 0, 0, 3);
      expect_v("ch0_fl_lit", 1); tick(); observe(int'(light[0]));
      #3 reset = 1'b0;
      #1;
      expect_v("arst_light", 0);   observe(int'(light));
      expect_v("arst_selmode", 0); observe(int'(sel_mode));
      expect_v("arst_beat", 0);    observe(int'(beat));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      sel = 1'b0;
      expect_v("post_ch0", 0); tick(); observe(int'(sel_mode));
      sel = 1'b1;
      expect_v("post_ch1", 0); tick(); observe(int'(sel_mode));
      press(1, 0, 0, 2);
      expect_v("f1_reinit", 12); meas_half(1, c); observe(c);
      sel = 1'b0;
      press(1, 0, 0, 4);
      expect_v("post_dim", 4);   tick(); observe(int'(sel_mode));
      tick();
      expect_v("duty_reinit", 4); dim_count(0, c); observe(c);

      if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
